// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port (CPU / DMA) req/ack arbiter and fixed-sequence access
//            engine for a 256K x 16 asynchronous SRAM. Define SRAM_ARB_RR_EN
//            for round-robin arbitration; default is fixed CPU priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          nReset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_sel,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdat,
    output logic [DW-1:0] cpu_rdat,
    output logic          cpu_ack,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [1:0]    dma_sel,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wdat,
    output logic [DW-1:0] dma_rdat,
    output logic          dma_ack,

    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_WR2  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;      // 0 = CPU, 1 = DMA
    logic [1:0]    sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dq_o_q, dq_o_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          ub_n_q, ub_n_d;
    logic          lb_n_q, lb_n_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdat_q, cpu_rdat_d;
    logic [DW-1:0] dma_rdat_q, dma_rdat_d;
`ifdef SRAM_ARB_RR_EN
    logic          last_q, last_d;        // 1 = DMA was granted last
`endif

    logic          finishing;
    logic          cpu_elig;
    logic          dma_elig;
    logic          win_cpu;
    logic          win_dma;
    logic          win_we;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        cpu_rdat_d = cpu_rdat_q;
        dma_rdat_d = dma_rdat_q;
        win_we     = 1'b0;

        finishing  = (state_q == S_RD1) || (state_q == S_WR2);
        cpu_ack_d  = finishing && !grant_q;
        dma_ack_d  = finishing &&  grant_q;

        if (state_q == S_RD1) begin
            if (grant_q) begin
                dma_rdat_d = sram_dq_i;
            end else begin
                cpu_rdat_d = sram_dq_i;
            end
        end

        // The port being acked at this edge still shows its old request; keep it out.
        cpu_elig = cpu_req && !cpu_ack_d;
        dma_elig = dma_req && !dma_ack_d;

`ifdef SRAM_ARB_RR_EN
        last_d  = last_q;
        win_cpu = cpu_elig && (!dma_elig || last_q);
        win_dma = dma_elig && !win_cpu;
`else
        // Raw cpu_req blocks DMA even while the CPU is masked, so DMA never slips in.
        win_cpu = cpu_elig;
        win_dma = dma_elig && !cpu_req;
`endif

        case (state_q)
            S_RD0:   state_d = S_RD1;
            S_WR0:   state_d = S_WR1;
            S_WR1:   state_d = S_WR2;
            default: begin
                // IDLE and the last cycle of an access both hand the slot to a new winner.
                state_d = S_IDLE;
                if (win_cpu || win_dma) begin
                    grant_d = win_dma;
                    sel_d   = win_dma ? dma_sel : cpu_sel;
                    addr_d  = win_dma ? dma_adr : cpu_adr;
                    win_we  = win_dma ? dma_we  : cpu_we;
                    if (win_we) begin
                        state_d = S_WR0;
                        dq_o_d  = win_dma ? dma_wdat : cpu_wdat;
                    end else begin
                        state_d = S_RD0;
                    end
`ifdef SRAM_ARB_RR_EN
                    last_d = win_dma;
`endif
                end
            end
        endcase

        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            S_RD0, S_RD1: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = ~sel_d[1];
                lb_n_d = ~sel_d[0];
            end
            S_WR0, S_WR2: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                ub_n_d  = ~sel_d[1];
                lb_n_d  = ~sel_d[0];
            end
            S_WR1: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                ub_n_d  = ~sel_d[1];
                lb_n_d  = ~sel_d[0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            sel_q      <= 2'b00;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            cpu_rdat_q <= '0;
            dma_rdat_q <= '0;
`ifdef SRAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
            cpu_rdat_q <= cpu_rdat_d;
            dma_rdat_q <= dma_rdat_d;
`ifdef SRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
    assign cpu_rdat   = cpu_rdat_q;
    assign dma_rdat   = dma_rdat_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed self-checking bench for sram_arbiter with a small
//            behavioural SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          nReset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0]    cpu_sel, dma_sel;
    logic [AW-1:0] cpu_adr, dma_adr;
    logic [DW-1:0] cpu_wdat, dma_wdat, cpu_rdat, dma_rdat;
    logic          cpu_ack, dma_ack;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [4:0]    strb;

    logic [15:0]   mem [0:255];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [1:0]    lanes_seen;
    int            we_low_cnt;
    int            oe_cnt;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .nReset(nReset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_adr(cpu_adr),
        .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_sel(dma_sel), .dma_adr(dma_adr),
        .dma_wdat(dma_wdat), .dma_rdat(dma_rdat), .dma_ack(dma_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    assign strb      = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    // Asynchronous SRAM: data latched on the rising edge of we_n, per enabled lane.
    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] = sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq_o[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_acc(input logic dma, input logic we, input logic [AW-1:0] adr,
                           input logic [1:0] sel, input logic [15:0] wdat,
                           output int lat, output logic [15:0] rd);
        lanes_seen = 2'b00;
        we_low_cnt = 0;
        oe_cnt     = 0;
        lat        = 0;
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_adr = adr; dma_sel = sel; dma_wdat = wdat;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_sel = sel; cpu_wdat = wdat;
        end
        do begin
            tick();
            lat++;
            if (!sram_ce_n) lanes_seen = lanes_seen | {~sram_ub_n, ~sram_lb_n};
            if (!sram_we_n) we_low_cnt++;
            if (sram_dq_oe) oe_cnt++;
        end while (!(dma ? dma_ack : cpu_ack) && lat < 20);
        rd = dma ? dma_rdat : cpu_rdat;
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic [7:0]  order;
        int          nc, nd, both_ack, c20, c21, nacks, ack1_cyc, ack2_cyc;
        logic [15:0] rd1, rd2;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        nReset  = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 2'b00; cpu_adr = '0; cpu_wdat = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_sel = 2'b00; dma_adr = '0; dma_wdat = '0;
        #12;
        chk("reset_strobes", strb, 5'h1F);
        chk("reset_dq_oe", sram_dq_oe, 1'b0);
        chk("reset_addr", sram_addr, 0);
        chk("reset_dq_o", sram_dq_o, 0);
        chk("reset_acks", {cpu_ack, dma_ack}, 2'b00);
        chk("reset_rdat", {cpu_rdat, dma_rdat}, 0);
        nReset = 1'b1;

        // CPU word write 0x00004 <= 0xA0B0, checked cycle by cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 18'h00004; cpu_sel = 2'b11; cpu_wdat = 16'hA0B0;
        tick();
        chk("wr0_strobes", strb, 5'h0C);
        chk("wr0_dq_oe", sram_dq_oe, 1'b1);
        chk("wr0_addr", sram_addr, 18'h00004);
        chk("wr0_dq_o", sram_dq_o, 16'hA0B0);
        tick();
        chk("wr1_strobes", strb, 5'h08);
        chk("wr1_ack", cpu_ack, 1'b0);
        tick();
        chk("wr2_strobes", strb, 5'h0C);
        chk("wr2_mem", mem[4], 16'hA0B0);
        tick();
        chk("wr_ack_e3", cpu_ack, 1'b1);
        chk("wr_ack_strobes", strb, 5'h1F);
        chk("wr_ack_dq_oe", sram_dq_oe, 1'b0);
        cpu_req = 1'b0;
        tick();
        chk("wr_ack_pulse", cpu_ack, 1'b0);
        chk("wr_no_reissue", strb, 5'h1F);

        run_acc(1'b0, 1'b0, 18'h00004, 2'b11, 16'h0000, lat, rd);
        chk("cpu_rd_lat", lat, 3);
        chk("cpu_rd_data", rd, 16'hA0B0);
        chk("cpu_rd_lanes", lanes_seen, 2'b11);
        chk("cpu_rd_no_we", we_low_cnt, 0);
        chk("cpu_rd_no_oe", oe_cnt, 0);
        chk("dma_rdat_kept", dma_rdat, 16'h0000);

        // DMA lower-byte write into 0xFFFF
        mem[16] = 16'hFFFF;
        run_acc(1'b1, 1'b1, 18'h00010, 2'b01, 16'h1234, lat, rd);
        chk("dma_wr_lat", lat, 4);
        chk("dma_wr_lanes", lanes_seen, 2'b01);
        chk("dma_wr_we_low", we_low_cnt, 1);
        chk("dma_wr_oe_cyc", oe_cnt, 3);
        run_acc(1'b1, 1'b0, 18'h00010, 2'b11, 16'h0000, lat, rd);
        chk("dma_rd_lat", lat, 3);
        chk("dma_rd_data", rd, 16'hFF34);
        chk("cpu_rdat_kept", cpu_rdat, 16'hA0B0);

        // Both ports stream four reads each
        cpu_we = 1'b0; cpu_adr = 18'h00004; cpu_sel = 2'b11;
        dma_we = 1'b0; dma_adr = 18'h00010; dma_sel = 2'b11;
        cpu_req = 1'b1; dma_req = 1'b1;
        order = 8'h00; nc = 0; nd = 0; both_ack = 0;
        for (int cyc = 0; cyc < 60 && (nc < 4 || nd < 4); cyc++) begin
            tick();
            if (cpu_ack && dma_ack) both_ack++;
            if (cpu_ack) begin
                order = {order[6:0], 1'b0};
                chk("arb_cpu_rdat", cpu_rdat, 16'hA0B0);
                nc++;
                if (nc == 4) cpu_req = 1'b0;
            end
            if (dma_ack) begin
                order = {order[6:0], 1'b1};
                chk("arb_dma_rdat", dma_rdat, 16'hFF34);
                nd++;
                if (nd == 4) dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("arb_counts", {nc[7:0], nd[7:0]}, 16'h0404);
        chk("arb_both_ack", both_ack, 0);
`ifdef SRAM_ARB_RR_EN
        chk("arb_order_rr", order, 8'h55);
`else
        chk("arb_order_fixed", order, 8'h0F);
`endif
        tick();

        // CPU keeps req high and moves to the next address as ack rises
        mem[32] = 16'h1111; mem[33] = 16'h2222;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 18'h00020; cpu_sel = 2'b11;
        c20 = 0; c21 = 0; nacks = 0; ack1_cyc = 0; ack2_cyc = 0; rd1 = '0; rd2 = '0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            if (!sram_ce_n && sram_addr == 18'h00020) c20++;
            if (!sram_ce_n && sram_addr == 18'h00021) c21++;
            if (cpu_ack) begin
                nacks++;
                if (nacks == 1) begin
                    rd1 = cpu_rdat; ack1_cyc = cyc; cpu_adr = 18'h00021;
                end else if (nacks == 2) begin
                    rd2 = cpu_rdat; ack2_cyc = cyc; cpu_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        chk("hold_nacks", nacks, 2);
        chk("hold_cyc_0x20", c20, 2);
        chk("hold_cyc_0x21", c21, 2);
        chk("hold_rd1", rd1, 16'h1111);
        chk("hold_rd2", rd2, 16'h2222);
        chk("hold_ack_gap", ack2_cyc - ack1_cyc, 3);

        // Reset asserted mid-write (WR1)
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 18'h00030; cpu_sel = 2'b11; cpu_wdat = 16'hBEEF;
        tick();
        tick();
        chk("rst_wr1_we_low", sram_we_n, 1'b0);
        #2;
        nReset = 1'b0;
        #1;
        chk("rst_async_strobes", strb, 5'h1F);
        chk("rst_async_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_async_addr", sram_addr, 0);
        chk("rst_async_rdat", cpu_rdat, 16'h0000);
        cpu_req = 1'b0;
        tick();
        chk("rst_no_ack0", {cpu_ack, dma_ack}, 2'b00);
        tick();
        chk("rst_no_ack1", {cpu_ack, dma_ack}, 2'b00);
        #3;
        nReset = 1'b1;
        run_acc(1'b0, 1'b0, 18'h00004, 2'b11, 16'h0000, lat, rd);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 16'hA0B0);

        // No byte lanes selected
        mem[64] = 16'h5555;
        run_acc(1'b0, 1'b1, 18'h00040, 2'b00, 16'hAAAA, lat, rd);
        chk("sel00_wr_lat", lat, 4);
        chk("sel00_wr_lanes", lanes_seen, 2'b00);
        chk("sel00_wr_we_low", we_low_cnt, 1);
        chk("sel00_wr_mem", mem[64], 16'h5555);
        run_acc(1'b0, 1'b0, 18'h00040, 2'b00, 16'h0000, lat, rd);
        chk("sel00_rd_lat", lat, 3);
        chk("sel00_rd_lanes", lanes_seen, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
